serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Bit-serial addition sequencer that shares one instance of the existing gate-level `full_adder` cell across all bit positions of a WIDTH-bit add.
- Accepts an operand pair via valid/ready, feeds one bit pair per cycle LSB-first through the adder, holds the carry in a flop, and assembles the result in a shift register.
- Sits between a requester and downstream logic as the area-minimal add resource for the synthesized flat netlist flow.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- op  input  1  0 = add, 1 = subtract; sampled on accept; ignored unless the optional feature is compiled in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result, stable while out_valid=1.
- co  output  1  final carry-out (for subtract: 1 = no borrow).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, co=0, carry flop=0, counter=0, operand shift registers=0.
- FSM states: IDLE, RUN, DONE (one-hot or binary; encoding is free).
- IDLE:
  - in_ready=1.
  - Accept on in_valid & in_ready: load a/b into shift registers, load carry flop with 0 (add), counter=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the full_adder receives a=a_sr[0], b=b_sr[0], ci=carry.
  - On the clock edge:
    - adder sum bit enters result register at the MSB, and the result register shifts right.
    - a_sr and b_sr shift right.
    - carry takes the adder co.
    - counter increments.
  - When counter==WIDTH-1 at the edge, go to DONE. RUN therefore lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1; sum=result register; co=carry flop.
  - Hold until out_ready=1, then go to IDLE at that edge. out_valid drops the following cycle.
- Latency: accept edge at cycle 0 -> out_valid high from cycle WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles, with no back-pressure.
- No overlap: in_ready is 0 in RUN and DONE, and in_valid is ignored there. A new accept is possible in the cycle after DONE exits.
- Back-pressure: sum/co stay stable for any number of cycles while out_valid=1 and out_ready=0.
- Wrap-around: the sum is modulo 2^WIDTH. The overflow bit is reported only via co.
- Reset mid-operation: rst in RUN or DONE returns to IDLE with the reset values next cycle. The partial result is discarded, and out_valid is never asserted for the aborted operation.
- Counter never exceeds WIDTH-1; no other states are reachable. An illegal state decodes to IDLE.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: SERIAL_ADD_SEQ_SUB_EN.
- Defined:
  - op is honoured.
  - op=1 loads b_sr with ~b and carry flop with 1, so the block computes a-b as two's complement. co=1 means a>=b unsigned.
  - op is captured on accept and is constant for the whole operation.
- Undefined:
  - op port is present but unconnected internally; every operation is an add.
  - No inverter and no op capture flop are synthesized.

Decomposition:
- Package serial_add_pkg:
  - state enum typedef (IDLE/RUN/DONE).
  - localparam for the add/subtract op encoding.
- One sub-module: an instance of the existing `full_adder` cell. Its ports a, b, ci, sum, co are wired directly to the shift-register LSBs, the carry flop, and the result input.
- No other hierarchy.

Test Plan:
- WIDTH=8. a=8'h5A, b=8'hA5, op=0 -> out_valid exactly at cycle 9 after accept; sum=8'hFF, co=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, co=1 (wrap-around).
- a=8'h03, b=8'h04; out_ready held 0 for 5 cycles after out_valid:
  - sum=8'h07 stable throughout.
  - in_valid asserted during RUN/DONE not accepted.
  - next op accepted the cycle after the handshake.
- Accept a=8'h0F, b=8'h01, assert rst at RUN cycle 3:
  - next cycle state IDLE, in_ready=1, out_valid=0.
  - a following op 8'h01+8'h01 returns 8'h02, co=0 (no carry leakage).
- With SERIAL_ADD_SEQ_SUB_EN:
  - 8'h10 - 8'h01 -> sum=8'h0F, co=1.
  - 8'h01 - 8'h02 -> sum=8'hFF, co=0.
  - Without the macro, op=1 with 8'h10, 8'h01 -> sum=8'h11.
- Back-to-back streaming of 4 random pairs with in_valid held high: results match a scoreboard, and the accept spacing is exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add sequencer: FSM state and op encoding.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Gate-level one-bit full adder cell, shared across all bit positions of the serial add.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic ab_x;

  assign ab_x = a ^ b;
  assign sum  = ab_x ^ ci;
  assign co   = (a & b) | (ci & ab_x);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: one full_adder, LSB-first, result in a shift register.
// Define SERIAL_ADD_SEQ_SUB_EN to honour op (1 = subtract via ~b and carry-in 1).
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_sr_reg, b_sr_reg, res_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               fa_sum, fa_co;
  logic               cnt_last;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

`ifdef SERIAL_ADD_SEQ_SUB_EN
  // Subtract is a + ~b + 1; the op choice is folded into the loaded operand and carry.
  assign b_load     = (op == OP_SUB) ? ~b : b;
  assign carry_load = (op == OP_SUB);
`else
  logic unused_op;
  assign unused_op  = op;
  assign b_load     = b;
  assign carry_load = OP_ADD;
`endif

  assign cnt_last = (cnt_reg == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .a   (a_sr_reg[0]),
    .b   (b_sr_reg[0]),
    .ci  (carry_reg),
    .sum (fa_sum),
    .co  (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b_load;
            carry_reg <= carry_load;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
          res_reg   <= {fa_sum, res_reg[WIDTH-1:1]};
          a_sr_reg  <= a_sr_reg >> 1;
          b_sr_reg  <= b_sr_reg >> 1;
          carry_reg <= fa_co;
          cnt_reg   <= cnt_last ? '0 : cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt_last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sum = res_reg;
  assign co  = carry_reg;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed cases plus randomized ops vs. an arithmetic model.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;

  int total = 0;
  int bad   = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; returns {carry_out, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic o);
    logic [W:0] r;
`ifdef SERIAL_ADD_SEQ_SUB_EN
    if (o) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
      return r;
    end
`endif
    r = {1'b0, x} + {1'b0, y};
    return r;
  endfunction

  // Drive one operation from a negedge; returns observed result, latency in edges, ok=0 on timeout.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xo,
                        input int hold, output logic [W-1:0] rs, output logic rc,
                        output int lat, output bit ok);
    int k;
    ok = 1'b1;
    rs = '0;
    rc = 1'b0;
    lat = 0;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      return;
    end
    a = xa; b = xb; op = xo; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      ok = 1'b0;
      return;
    end
    rs = sum;
    rc = co;
    out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL reset_co got=%b want=0", co); end
    $display("reset: in_ready=%b out_valid=%b sum=%h co=%b", in_ready, out_valid, sum, co);
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                               input logic xo, input logic [W-1:0] want_s, input logic want_c);
    logic [W-1:0] rs; logic rc; int lat; bit ok;
    run_op(xa, xb, xo, 0, rs, rc, lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_timeout got=timeout want=result", name); end
    total++; if (lat != W) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, W); end
    total++; if (rs !== want_s) begin bad++; $display("FAIL %s_sum got=%h want=%h", name, rs, want_s); end
    total++; if (rc !== want_c) begin bad++; $display("FAIL %s_co got=%b want=%b", name, rc, want_c); end
    $display("%s: a=%h b=%h op=%b -> sum=%h co=%b lat=%0d", name, xa, xb, xo, rs, rc, lat);
  endtask

  task automatic test_backpressure();
    int k; bit ready_leak;
    ready_leak = 1'b0;
    a = 8'h03; b = 8'h04; op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    // Keep offering a different pair during RUN/DONE; it must not be taken.
    a = 8'hAA; b = 8'h11;
    k = 0;
    while (!out_valid && k < 100) begin
      if (in_ready) ready_leak = 1'b1;
      @(negedge clk);
      k++;
    end
    total++; if (!out_valid) begin bad++; $display("FAIL bp_timeout got=timeout want=out_valid"); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (sum !== 8'h07 || co !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d got=sum %h co %b v %b want=sum 07 co 0 v 1", i, sum, co, out_valid);
      end
      if (in_ready) ready_leak = 1'b1;
      @(negedge clk);
    end
    total++; if (ready_leak) begin bad++; $display("FAIL bp_in_ready got=1 want=0 during RUN/DONE"); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got=v %b r %b want=v 0 r 1", out_valid, in_ready);
    end
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got=%b want=0", in_ready); end
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (sum !== 8'hBB || co !== 1'b0) begin
      bad++; $display("FAIL bp_next_result got=%h/%b want=bb/0", sum, co);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("backpressure: held sum 07, next op result=%h", 8'hBB);
  endtask

  task automatic test_reset_mid();
    bit seen_valid;
    a = 8'h0F; b = 8'h01; op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || co !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state got=r %b v %b s %h c %b want=r 1 v 0 s 00 c 0",
               in_ready, out_valid, sum, co);
    end
    seen_valid = 1'b0;
    repeat (W + 2) begin
      if (out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    total++; if (seen_valid) begin bad++; $display("FAIL midrst_ghost got=out_valid want=none"); end
    $display("reset_mid: aborted 0f+01, in_ready=%b", in_ready);
    test_directed("post_reset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
  endtask

  task automatic test_sub();
`ifdef SERIAL_ADD_SEQ_SUB_EN
    test_directed("sub_nb", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    test_directed("sub_borrow", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
`else
    test_directed("op_ignored", 8'h10, 8'h01, 1'b1, 8'h11, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] xa, xb, rs; logic xo, rc; logic [W:0] e; int lat; bit ok;
    for (int i = 0; i < 12; i++) begin
      xa = W'($urandom); xb = W'($urandom); xo = 1'($urandom);
      e = model(xa, xb, xo);
      run_op(xa, xb, xo, int'($urandom_range(0, 3)), rs, rc, lat, ok);
      total++;
      if (!ok || lat != W || rs !== e[W-1:0] || rc !== e[W]) begin
        bad++;
        $display("FAIL rand%0d got=%h/%b lat %0d ok %0d want=%h/%b lat %0d",
                 i, rs, rc, lat, ok, e[W-1:0], e[W], W);
      end
      $display("rand%0d: a=%h b=%h op=%b -> sum=%h co=%b", i, xa, xb, xo, rs, rc);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] expq[$];
    logic [W:0] e;
    int acc_t[4];
    int t, n, got;
    bit pending;
    t = 0; n = 0; got = 0; pending = 1'b0;
    out_ready = 1'b1;
    a = W'($urandom); b = W'($urandom); op = 1'($urandom); in_valid = 1'b1;
    for (int it = 0; it < 200 && got < 4; it++) begin
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, op));
        acc_t[n] = t;
        n++;
        pending = 1'b1;
      end
      if (out_valid) begin
        e = expq.pop_front();
        total++;
        if (sum !== e[W-1:0] || co !== e[W]) begin
          bad++; $display("FAIL b2b_result%0d got=%h/%b want=%h/%b", got, sum, co, e[W-1:0], e[W]);
        end
        $display("b2b%0d: sum=%h co=%b", got, sum, co);
        got++;
      end
      if (got < 4) begin
        @(negedge clk);
        t++;
        if (pending) begin
          pending = 1'b0;
          if (n < 4) begin
            a = W'($urandom); b = W'($urandom); op = 1'($urandom);
          end else begin
            in_valid = 1'b0;
          end
        end
      end
    end
    total++; if (got != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got); end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (i < n && acc_t[i] - acc_t[i-1] != W + 2) begin
        bad++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", i, acc_t[i] - acc_t[i-1], W + 2);
      end else if (i >= n) begin
        bad++; $display("FAIL b2b_spacing%0d got=missing want=%0d", i, W + 2);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed("basic", 8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0);
    test_directed("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    test_backpressure();
    test_reset_mid();
    test_sub();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
